// File: rtl/reg_bank_read.sv
// reg_bank_read: 32x32 register bank, one write port, registered A/B
// operand capture with optional write bypass, combinational debug read.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   RegWrite, WriteReg,
//   WriteDataFio        : write enable, destination index, write data
//   ReadReg1, ReadReg2  : rs/rt indices captured into AFio/BFio
//   LoadAB              : capture enable for AFio/BFio
//   AFio, BFio          : registered operands
//   DbgReg, DbgData     : combinational debug read (no bypass)
//   WriteAck            : one-cycle pulse after a write to r1..r31
module reg_bank_read #(
    parameter int          SP_INDEX  = 29,
    parameter logic [31:0] SP_RESET  = 32'd227,
    parameter bit          BYPASS_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic [4:0]  WriteReg,
    input  logic [31:0] WriteDataFio,
    input  logic [4:0]  ReadReg1,
    input  logic [4:0]  ReadReg2,
    input  logic        LoadAB,
    output logic [31:0] AFio,
    output logic [31:0] BFio,
    input  logic [4:0]  DbgReg,
    output logic [31:0] DbgData,
    output logic        WriteAck
);

    logic [31:0] regs_q [32];
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        ack_q, ack_d;
    logic        wr_en;

    // RegWrite gates the index so an undriven WriteReg is harmless.
    assign wr_en = RegWrite && (WriteReg != 5'd0);

    function automatic logic [31:0] rd(input logic [4:0] idx);
        logic [31:0] v;
        if (idx == 5'd0)
            v = 32'd0;
        else if (BYPASS_EN && wr_en && (idx == WriteReg))
            v = WriteDataFio;
        else
            v = regs_q[idx];
        return v;
    endfunction

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        ack_d = wr_en;
        if (LoadAB) begin
            a_d = rd(ReadReg1);
            b_d = rd(ReadReg2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                regs_q[i] <= (i == SP_INDEX) ? SP_RESET : 32'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            ack_q <= 1'b0;
        end else begin
            if (wr_en)
                regs_q[WriteReg] <= WriteDataFio;
            a_q   <= a_d;
            b_q   <= b_d;
            ack_q <= ack_d;
        end
    end

    assign DbgData  = (DbgReg == 5'd0) ? 32'd0 : regs_q[DbgReg];
    assign AFio     = a_q;
    assign BFio     = b_q;
    assign WriteAck = ack_q;

endmodule

// File: tb/tb_reg_bank_read.sv
// tb_reg_bank_read: directed checks of reg_bank_read, with one bypassing
// and one non-bypassing instance driven by the same stimulus.
module tb_reg_bank_read;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteDataFio;
    logic [4:0]  ReadReg1, ReadReg2;
    logic        LoadAB;
    logic [4:0]  DbgReg;
    logic [31:0] a0, b0, d0, a1, b1, d1;
    logic        ack0, ack1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_bank_read #(.BYPASS_EN(1'b1)) u_byp (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .WriteReg(WriteReg), .WriteDataFio(WriteDataFio),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .LoadAB(LoadAB),
        .AFio(a0), .BFio(b0), .DbgReg(DbgReg), .DbgData(d0),
        .WriteAck(ack0)
    );

    reg_bank_read #(.BYPASS_EN(1'b0)) u_nob (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .WriteReg(WriteReg), .WriteDataFio(WriteDataFio),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .LoadAB(LoadAB),
        .AFio(a1), .BFio(b1), .DbgReg(DbgReg), .DbgData(d1),
        .WriteAck(ack1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg(input logic [4:0] idx, input logic [31:0] exp);
        DbgReg = idx;
        #1;
        chk($sformatf("dbg0[%0d]", idx), d0, exp);
        chk($sformatf("dbg1[%0d]", idx), d1, exp);
    endtask

    initial begin
        reset = 1'b1;
        RegWrite = 1'b0;
        WriteReg = 5'd0;
        WriteDataFio = 32'd0;
        ReadReg1 = 5'd0;
        ReadReg2 = 5'd0;
        LoadAB = 1'b0;
        DbgReg = 5'd0;

        step();
        step();
        chk("rst_a0", a0, 0);
        chk("rst_b0", b0, 0);
        chk("rst_a1", a1, 0);
        chk("rst_ack0", {31'd0, ack0}, 0);
        for (int i = 0; i < 32; i++)
            dbg(5'(i), (i == 29) ? 32'd227 : 32'd0);
        reset = 1'b0;

        RegWrite = 1'b1;
        WriteReg = 5'd8;
        WriteDataFio = 32'hDEADBEEF;
        step();
        chk("wr_ack", {31'd0, ack0}, 1);
        RegWrite = 1'b0;
        ReadReg1 = 5'd8;
        ReadReg2 = 5'd29;
        LoadAB = 1'b1;
        step();
        chk("basic_a", a0, 32'hDEADBEEF);
        chk("basic_b", b0, 32'd227);
        chk("basic_a1", a1, 32'hDEADBEEF);
        chk("basic_ack", {31'd0, ack0}, 0);
        LoadAB = 1'b0;

        RegWrite = 1'b1;
        WriteReg = 5'd0;
        WriteDataFio = 32'h12345678;
        step();
        chk("z_ack", {31'd0, ack0}, 0);
        RegWrite = 1'b0;
        ReadReg1 = 5'd0;
        ReadReg2 = 5'd0;
        LoadAB = 1'b1;
        step();
        chk("z_a", a0, 0);
        chk("z_b", b0, 0);
        chk("z_ack2", {31'd0, ack0}, 0);
        dbg(5'd0, 32'd0);
        LoadAB = 1'b0;

        RegWrite = 1'b1;
        WriteReg = 5'd5;
        WriteDataFio = 32'h11;
        step();
        WriteDataFio = 32'h22;
        ReadReg1 = 5'd5;
        ReadReg2 = 5'd5;
        LoadAB = 1'b1;
        dbg(5'd5, 32'h11);
        step();
        chk("byp_a", a0, 32'h22);
        chk("byp_b", b0, 32'h22);
        chk("nob_a", a1, 32'h11);
        chk("nob_b", b1, 32'h11);
        dbg(5'd5, 32'h22);
        RegWrite = 1'b0;
        LoadAB = 1'b0;
        step();
        chk("byp_hold", a0, 32'h22);

        reset = 1'b1;
        RegWrite = 1'b1;
        WriteReg = 5'd9;
        WriteDataFio = 32'hFF;
        LoadAB = 1'b1;
        ReadReg1 = 5'd9;
        step();
        chk("rc_a", a0, 0);
        chk("rc_ack", {31'd0, ack0}, 0);
        dbg(5'd9, 32'd0);
        dbg(5'd5, 32'd0);
        reset = 1'b0;
        LoadAB = 1'b0;
        step();
        chk("rc_ack2", {31'd0, ack0}, 1);
        dbg(5'd9, 32'hFF);
        RegWrite = 1'b0;
        WriteReg = 5'bx;
        step();
        chk("rc_ack3", {31'd0, ack0}, 0);

        ReadReg1 = 5'd9;
        ReadReg2 = 5'd29;
        LoadAB = 1'b1;
        step();
        chk("pre_a", a0, 32'hFF);
        chk("pre_b", b0, 32'd227);
        LoadAB = 1'b0;

        RegWrite = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            WriteReg = 5'(k);
            WriteDataFio = 32'(k * 3);
            step();
            chk($sformatf("st_ack%0d", k), {31'd0, ack0}, 1);
            chk($sformatf("st_a%0d", k), a0, 32'hFF);
            chk($sformatf("st_b%0d", k), b1, 32'd227);
        end
        RegWrite = 1'b0;
        step();
        chk("st_end_ack", {31'd0, ack0}, 0);
        for (int i = 0; i < 32; i++)
            dbg(5'(i), 32'(i * 3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_bank_read.md
Name: reg_bank_read

Overview:
- 32 x 32-bit general-purpose register bank for the multicycle MIPS datapath. It is the consumer of the write-data selector output.
- Accepts one write per cycle: WriteDataFio into register WriteReg when RegWrite is high.
- Provides two read ports, rs and rt, each captured into an A/B operand register under a load enable, for use by the ALU-input muxes in the next state.
- Provides a combinational debug read port for testbenches.

Parameters:
- SP_INDEX, 29, index of the stack pointer register.
- SP_RESET, 32'd227, reset value loaded into register SP_INDEX.
- BYPASS_EN, 1, 1 = a same-cycle write forwards into the A/B capture; 0 = A/B capture the pre-write array value.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- RegWrite  in  1  write enable for the array.
- WriteReg  in  5  destination register index.
- WriteDataFio  in  32  write data from the write-data selector.
- ReadReg1  in  5  rs index for port A.
- ReadReg2  in  5  rt index for port B.
- LoadAB  in  1  capture enable for the A and B output registers.
- AFio  out  32  registered operand A.
- BFio  out  32  registered operand B.
- DbgReg  in  5  debug read index.
- DbgData  out  32  combinational read of array[DbgReg]; reads 0 for index 0.
- WriteAck  out  1  registered pulse: high for exactly one cycle after an accepted write to a nonzero register.

Behaviour:
- Clock domain and reset
  - Single clock domain; every update happens on the rising edge of clk.
- Synchronous reset (reset=1 at the edge)
  - All 32 array entries = 0, except entry SP_INDEX = SP_RESET.
  - AFio = 0, BFio = 0, WriteAck = 0.
  - Reset overrides RegWrite and LoadAB in the same cycle: no write, no capture.
- Register 0
  - Hardwired to zero. Writes to index 0 are discarded and produce no WriteAck.
  - Any read of index 0 (A, B, Dbg) returns 0.
- Write
  - When RegWrite=1, reset=0 and WriteReg!=0, array[WriteReg] <= WriteDataFio at the edge.
  - WriteAck=1 during the following cycle only.
  - Back-to-back writes on consecutive cycles are all accepted. WriteAck stays high for each of them.
- Capture
  - When LoadAB=1 and reset=0: AFio <= rd(ReadReg1) and BFio <= rd(ReadReg2).
  - Latency is one cycle from index presentation to AFio/BFio.
  - When LoadAB=0, AFio and BFio hold their values.
- Simultaneous write and capture, with BYPASS_EN=1
  - If RegWrite=1, WriteReg!=0 and ReadReg1==WriteReg, AFio captures WriteDataFio. Same rule for B with ReadReg2.
  - Both ports may bypass in the same cycle when ReadReg1==ReadReg2==WriteReg.
- Simultaneous write and capture, with BYPASS_EN=0
  - A/B capture the old array contents; the array still updates.
- DbgData
  - Purely combinational from the array. It reflects a write only after the edge and never bypasses.
- Reset mid-operation
  - Any write or capture presented in the reset cycle is lost.
  - The first accepted operation is in the cycle after reset deasserts.
- Undefined inputs
  - X on WriteReg while RegWrite=0 has no effect.

Test Plan:
- Reset values: assert reset for 2 cycles, then sweep DbgReg 0..31.
  - DbgData = 0 everywhere except index 29 = 227.
  - AFio = BFio = 0, WriteAck = 0.
- Basic write/read: write 0xDEADBEEF to r8; next cycle ReadReg1=8, ReadReg2=29, LoadAB=1.
  - One cycle later AFio = 0xDEADBEEF, BFio = 227.
  - WriteAck high for exactly the cycle after the write.
- Zero register: RegWrite=1, WriteReg=0, data 0x12345678; then capture ReadReg1=ReadReg2=0.
  - AFio = BFio = 0, WriteAck stays 0, DbgData(0) = 0.
- Bypass (BYPASS_EN=1): r5 holds 0x11. In one cycle apply RegWrite=1, WriteReg=5, WriteDataFio=0x22, LoadAB=1, ReadReg1=ReadReg2=5.
  - AFio = BFio = 0x22.
  - Repeat with BYPASS_EN=0: AFio = BFio = 0x11, DbgData(5) = 0x22 afterwards.
- Reset collision: RegWrite=1 to r9 with 0xFF and LoadAB=1, all with reset=1.
  - r9 = 0, AFio = 0, WriteAck = 0.
  - A write of 0xFF to r9 in the next cycle lands and WriteAck pulses.
- Hold and streaming: 31 consecutive writes rk = k*3 for k = 1..31, with LoadAB=0 throughout.
  - AFio/BFio are unchanged.
  - WriteAck stays high for 31 cycles.
  - Debug sweep matches k*3, with r29 overwritten to 87.
